// File: rtl/gray_pkg.sv
// Shared gray-code helpers and decoder state types, used by both the decoder
// and the counter side of any gray-coded pointer interface.
package gray_pkg;

  // Widest code the helpers handle; narrower codes are zero-extended.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_UP,
    MOVE_DOWN,
    MOVE_ILLEGAL
  } move_t;

  // Prefix XOR from the MSB down; zero-extension leaves the low bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Flop chain that brings a gray code into the local clock domain.
// STAGES = 0 passes the code straight through.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] stage [STAGES];

      // NOTE: this small array is reset on purpose so the decoder starts from a known code; large memories normally are not.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/gray_code_decoder.sv
// Receive side of a gray-coded counter: synchronizes, converts to binary,
// classifies each move and keeps an extended position and an error count.
module gray_code_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_WIDTH   = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic [POS_WIDTH-1:0] pos_out,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 locked
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES);

  logic [WIDTH-1:0] sync_g;
  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] diff;
  move_t            move;

  state_t                state, state_next;
  logic [SETTLE_W-1:0]   settle_cnt, settle_next;
  logic [POS_WIDTH-1:0]  pos_next;
  logic [ERR_WIDTH-1:0]  err_cnt_next;
  logic                  up_next, down_next, wrap_next, err_next;

  gray_sync #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (gray_in),
    .q    (sync_g)
  );

  assign cur_bin = WIDTH'(gray2bin(GRAY_MAX_W'(sync_g)));
  assign diff    = cur_bin - prev_bin;
  assign locked  = (state == TRACK);

  always_comb begin
    move = MOVE_ILLEGAL;
    if (diff == '0)                move = MOVE_NONE;
    else if (diff == WIDTH'(1))    move = MOVE_UP;
    else if (diff == '1)           move = MOVE_DOWN;
  end

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    settle_next  = settle_cnt;
    pos_next     = pos_out;
    err_cnt_next = err_count;
    up_next      = 1'b0;
    down_next    = 1'b0;
    err_next     = 1'b0;

    if (clear_err) begin
      err_cnt_next = '0;
      settle_next  = '0;
      state_next   = INIT;
    end else begin
      unique case (state)
        INIT: begin
          // Wait until the sync chain and prev_bin hold the same settled code.
          if (settle_cnt == SETTLE_LAST) state_next  = TRACK;
          else                           settle_next = settle_cnt + SETTLE_W'(1);
        end
        TRACK: begin
          unique case (move)
            MOVE_UP: begin
              up_next  = 1'b1;
              pos_next = pos_out + POS_WIDTH'(1);
            end
            MOVE_DOWN: begin
              down_next = 1'b1;
              pos_next  = pos_out - POS_WIDTH'(1);
            end
            MOVE_ILLEGAL: begin
              err_next   = 1'b1;
              state_next = FAULT;
              if (err_count != '1) err_cnt_next = err_count + ERR_WIDTH'(1);
            end
            default: ;
          endcase
        end
        FAULT: begin
          if (move == MOVE_ILLEGAL) begin
            err_next = 1'b1;
            if (err_count != '1) err_cnt_next = err_count + ERR_WIDTH'(1);
          end
        end
        default: state_next = INIT;
      endcase
    end

    wrap_next = (up_next   && (prev_bin == '1)) ||
                (down_next && (prev_bin == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      settle_cnt <= '0;
      prev_bin   <= '0;
      bin_out    <= '0;
      pos_out    <= '0;
      err_count  <= '0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      prev_bin   <= cur_bin;
      bin_out    <= cur_bin;
      pos_out    <= pos_next;
      err_count  <= err_cnt_next;
      step_up    <= up_next;
      step_down  <= down_next;
      wrap       <= wrap_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_gray_code_decoder.sv
// Directed bench for gray_code_decoder (WIDTH=4, SYNC_STAGES=2, POS_WIDTH=16).
module tb_gray_code_decoder;

  typedef struct {
    logic [3:0]  gray;
    logic [3:0]  bin;
    logic        up;
    logic        down;
    logic        wrap;
    logic        err;
    logic [15:0] pos;
    logic [7:0]  errc;
    logic        locked;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [3:0]  gray_in;
  logic        clear_err;
  logic [3:0]  bin_out;
  logic [15:0] pos_out;
  logic        step_up;
  logic        step_down;
  logic        wrap;
  logic        err;
  logic [7:0]  err_count;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  gray_code_decoder #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .POS_WIDTH  (16),
    .ERR_WIDTH  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .gray_in  (gray_in),
    .clear_err(clear_err),
    .bin_out  (bin_out),
    .pos_out  (pos_out),
    .step_up  (step_up),
    .step_down(step_down),
    .wrap     (wrap),
    .err      (err),
    .err_count(err_count),
    .locked   (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] g, input logic [3:0] b, input logic u,
                              input logic d, input logic w, input logic e,
                              input logic [15:0] p, input logic [7:0] ec, input logic lk);
    vec_t v;
    v.gray = g; v.bin = b; v.up = u; v.down = d; v.wrap = w; v.err = e;
    v.pos = p; v.errc = ec; v.locked = lk;
    return v;
  endfunction

  // Apply one code and check outputs on the edge where it reaches bin_out.
  task automatic apply_vec(input vec_t v, input int idx);
    gray_in = v.gray;
    repeat (3) @(posedge clock);
    #1;
    check($sformatf("v%0d bin_out", idx),   32'(bin_out),   32'(v.bin));
    check($sformatf("v%0d step_up", idx),   32'(step_up),   32'(v.up));
    check($sformatf("v%0d step_down", idx), 32'(step_down), 32'(v.down));
    check($sformatf("v%0d wrap", idx),      32'(wrap),      32'(v.wrap));
    check($sformatf("v%0d err", idx),       32'(err),       32'(v.err));
    check($sformatf("v%0d pos_out", idx),   32'(pos_out),   32'(v.pos));
    check($sformatf("v%0d err_count", idx), 32'(err_count), 32'(v.errc));
    check($sformatf("v%0d locked", idx),    32'(locked),    32'(v.locked));
  endtask

  initial begin
    vec_t        tbl[$];
    logic [3:0]  seq[3];
    int          steps;
    int          errs;
    int          pulses;

    // Count up from bin 3 through 15 and wrap to 0, step down/up across the wrap,
    // then an illegal jump into FAULT where a legal move is ignored and another illegal one counts.
    tbl.push_back(mk(4'b0110,  4, 1, 0, 0, 0,  4, 0, 1));
    tbl.push_back(mk(4'b0111,  5, 1, 0, 0, 0,  5, 0, 1));
    tbl.push_back(mk(4'b0101,  6, 1, 0, 0, 0,  6, 0, 1));
    tbl.push_back(mk(4'b0100,  7, 1, 0, 0, 0,  7, 0, 1));
    tbl.push_back(mk(4'b1100,  8, 1, 0, 0, 0,  8, 0, 1));
    tbl.push_back(mk(4'b1101,  9, 1, 0, 0, 0,  9, 0, 1));
    tbl.push_back(mk(4'b1111, 10, 1, 0, 0, 0, 10, 0, 1));
    tbl.push_back(mk(4'b1110, 11, 1, 0, 0, 0, 11, 0, 1));
    tbl.push_back(mk(4'b1010, 12, 1, 0, 0, 0, 12, 0, 1));
    tbl.push_back(mk(4'b1011, 13, 1, 0, 0, 0, 13, 0, 1));
    tbl.push_back(mk(4'b1001, 14, 1, 0, 0, 0, 14, 0, 1));
    tbl.push_back(mk(4'b1000, 15, 1, 0, 0, 0, 15, 0, 1));
    tbl.push_back(mk(4'b0000,  0, 1, 0, 1, 0, 16, 0, 1));
    tbl.push_back(mk(4'b1000, 15, 0, 1, 1, 0, 15, 0, 1));
    tbl.push_back(mk(4'b0000,  0, 1, 0, 1, 0, 16, 0, 1));
    tbl.push_back(mk(4'b0100,  7, 0, 0, 0, 1, 16, 1, 0));
    tbl.push_back(mk(4'b0101,  6, 0, 0, 0, 0, 16, 1, 0));
    tbl.push_back(mk(4'b0000,  0, 0, 0, 0, 1, 16, 2, 0));

    seq[0] = 4'b0001;
    seq[1] = 4'b0011;
    seq[2] = 4'b0010;

    // Reset values
    reset     = 1'b0;
    gray_in   = 4'b0000;
    clear_err = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset bin_out", 32'(bin_out), 0);
    check("reset pos_out", 32'(pos_out), 0);
    check("reset err_count", 32'(err_count), 0);
    check("reset locked", 32'(locked), 0);
    check("reset pulses", 32'({step_up, step_down, wrap, err}), 0);

    // Settle and first three up steps with exact latency
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("init not locked", 32'(locked), 0);
    @(posedge clock);
    #1;
    check("init locked", 32'(locked), 1);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) gray_in = seq[k];
      @(posedge clock);
      #1;
      if (k >= 2) begin
        check($sformatf("seq bin_out k%0d", k), 32'(bin_out), 32'(k - 1));
        check($sformatf("seq step_up k%0d", k), 32'(step_up), 1);
      end else begin
        check($sformatf("seq early bin_out k%0d", k), 32'(bin_out), 0);
        check($sformatf("seq early step_up k%0d", k), 32'(step_up), 0);
      end
    end
    check("seq pos_out", 32'(pos_out), 3);
    check("seq locked", 32'(locked), 1);

    // Table-driven vectors
    foreach (tbl[i]) apply_vec(tbl[i], i);

    // clear_err leaves FAULT and re-references without a step
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    check("clear err_count", 32'(err_count), 0);
    check("clear locked0", 32'(locked), 0);
    check("clear err", 32'(err), 0);
    repeat (2) @(posedge clock);
    #1;
    check("clear locked2", 32'(locked), 0);
    @(posedge clock);
    #1;
    check("clear locked3", 32'(locked), 1);
    check("clear no step", 32'({step_up, step_down, err}), 0);
    check("clear pos_out", 32'(pos_out), 16);

    // clear_err wins over an illegal move arriving on the same edge
    gray_in = 4'b0100;
    repeat (2) @(posedge clock);
    #1;
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
    check("prio err", 32'(err), 0);
    check("prio err_count", 32'(err_count), 0);
    check("prio locked", 32'(locked), 0);
    check("prio bin_out", 32'(bin_out), 7);
    check("prio pos_out", 32'(pos_out), 16);
    repeat (3) @(posedge clock);
    #1;
    check("prio relock", 32'(locked), 1);
    check("prio no pulse", 32'({step_up, step_down, err}), 0);

    // Saturating error count in FAULT
    gray_in = 4'b0000;
    repeat (3) @(posedge clock);
    #1;
    check("fault entry err_count", 32'(err_count), 1);
    check("fault entry locked", 32'(locked), 0);
    steps = 0;
    errs  = 0;
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0101 : 4'b0000;
      @(posedge clock);
      #1;
      if (step_up || step_down) steps++;
      if (err) errs++;
    end
    repeat (4) begin
      @(posedge clock);
      #1;
      if (step_up || step_down) steps++;
      if (err) errs++;
    end
    check("sat steps", 32'(steps), 0);
    check("sat err pulses", 32'(errs), 300);
    check("sat err_count", 32'(err_count), 255);
    check("sat locked", 32'(locked), 0);
    check("sat pos_out", 32'(pos_out), 16);

    // Asynchronous reset mid-operation
    gray_in = 4'b0101;
    repeat (3) @(posedge clock);
    #1;
    check("pre-reset bin_out", 32'(bin_out), 6);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async bin_out", 32'(bin_out), 0);
    check("async pos_out", 32'(pos_out), 0);
    check("async err_count", 32'(err_count), 0);
    check("async locked", 32'(locked), 0);
    @(negedge clock);
    reset  = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (step_up || step_down || err) pulses++;
    end
    check("post-reset pulses", 32'(pulses), 0);
    check("post-reset locked", 32'(locked), 1);
    check("post-reset bin_out", 32'(bin_out), 6);
    check("post-reset pos_out", 32'(pos_out), 0);

    // Down step from 0 wraps position to all-ones, then back up to 0
    @(negedge clock);
    reset   = 1'b0;
    gray_in = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("rewrap locked", 32'(locked), 1);
    check("rewrap pos_out", 32'(pos_out), 0);
    apply_vec(mk(4'b1000, 15, 0, 1, 1, 0, 16'hFFFF, 0, 1), 100);
    apply_vec(mk(4'b0000,  0, 1, 0, 1, 0, 16'h0000, 0, 1), 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
